// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer.
//   state_e     : FSM states. The parser states live in uart_cmd_ctrl and the
//                 transmit states live in uart_tx_sched.
//   ACK_BYTE    : response to a good frame.
//   NAK_BYTE    : response to a bad frame.
//   HDR_DEFAULT : default frame header byte.
//   CMD_RD_BIT  : bit of the CMD byte that selects read (1) or write (0).
//   csum_ok()   : frame checksum test (CSUM == CMD ^ DATA).
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_CMD,
        GET_DATA,
        GET_CSUM,
        EXEC,
        TX_START,
        TX_WAIT_HI,
        TX_WAIT_LO
    } state_e;

    localparam logic [7:0] ACK_BYTE    = 8'h06;
    localparam logic [7:0] NAK_BYTE    = 8'h15;
    localparam logic [7:0] HDR_DEFAULT = 8'hA5;
    localparam int         CMD_RD_BIT  = 7;

    function automatic logic csum_ok(input logic [7:0] cmd,
                                     input logic [7:0] data,
                                     input logic [7:0] csum);
        return (cmd ^ data) == csum;
    endfunction

endpackage

// File: rtl/uart_tx_sched.sv
// Response transmitter for uart_cmd_ctrl. It accepts a one- or two-byte
// response request and feeds the bytes to the UART transmitter through the
// tx_start/tx_busy handshake.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   req_i         : one-cycle request; it is sampled only while idle
//   two_i         : 1 = send byte0_i then byte1_i, 0 = send byte0_i only
//   byte0_i/1_i   : response bytes, captured together with req_i
//   tx_busy_i     : transmitter busy
//   tx_data_o     : byte being transmitted; loaded before tx_start_o and held
//   tx_start_o    : one-cycle transmit request
//   done_o        : one-cycle pulse after the last byte has been sent
module uart_tx_sched
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic       two_i,
    input  logic [7:0] byte0_i,
    input  logic [7:0] byte1_i,
    input  logic       tx_busy_i,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o,
    output logic       done_o
);

    state_e     state_q;
    logic       second_q;
    logic [7:0] byte1_q;
    logic [7:0] tx_data_q;
    logic       tx_start_q;
    logic       done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            second_q   <= 1'b0;
            byte1_q    <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        // tx_data is loaded here so it is already stable
                        // when tx_start goes out.
                        tx_data_q <= byte0_i;
                        byte1_q   <= byte1_i;
                        second_q  <= two_i;
                        state_q   <= TX_START;
                    end
                end
                TX_START: begin
                    if (!tx_busy_i) begin
                        tx_start_q <= 1'b1;
                        state_q    <= TX_WAIT_HI;
                    end
                end
                TX_WAIT_HI: begin
                    if (tx_busy_i) begin
                        state_q <= TX_WAIT_LO;
                    end
                end
                TX_WAIT_LO: begin
                    if (!tx_busy_i) begin
                        if (second_q) begin
                            second_q  <= 1'b0;
                            tx_data_q <= byte1_q;
                            state_q   <= TX_START;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    assign done_o     = done_q;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer. Received bytes are assembled into 4-byte frames
// (HDR, CMD, DATA, CSUM). Each frame is checked, the configuration register
// bank is updated or read, and an ACK/NAK response (plus a data byte for reads)
// is sent through uart_tx_sched.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   tx_busy             : transmitter busy
//   tx_data, tx_start   : byte to transmit and its one-cycle request
//   cfg_regs            : flattened register bank, reg i at [8i+7:8i]
//   cfg_update          : one-cycle pulse after a register has been written
//   cfg_addr            : address of the last register written
// Build option: define UART_CMD_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYC idle cycles between bytes. Without it the parser waits forever.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int         NUM_REGS    = 4,
    parameter logic [7:0] HDR_BYTE    = HDR_DEFAULT,
    parameter int         TIMEOUT_CYC = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  tx_busy,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    output logic [8*NUM_REGS-1:0] cfg_regs,
    output logic                  cfg_update,
    output logic [6:0]            cfg_addr
);

    localparam logic [7:0] NREGS8 = 8'(NUM_REGS);

    if (NUM_REGS < 1 || NUM_REGS > 127 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_cmd_ctrl: illegal NUM_REGS or TIMEOUT_CYC");
    end

    state_e        state_q;
    logic [7:0]    cmd_q;
    logic [7:0]    data_q;
    logic [7:0]    csum_q;
    logic          cfg_update_q;
    logic [6:0]    cfg_addr_q;
    logic          req_q;
    logic          two_q;
    logic [7:0]    byte0_q;
    logic [7:0]    byte1_q;
    logic          tx_done;

    logic [6:0]          addr;
    logic                is_read;
    logic                frame_good;
    logic                exec_write;
    logic [7:0]          rd_byte;
    logic [NUM_REGS-1:0] wr_en;

    assign addr       = cmd_q[6:0];
    assign is_read    = cmd_q[CMD_RD_BIT];
    assign frame_good = csum_ok(cmd_q, data_q, csum_q) && ({1'b0, addr} < NREGS8);
    assign exec_write = (state_q == EXEC) && frame_good && !is_read;

    // Register bank: each register is written only by a good write frame.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [7:0] reg_q;
            assign wr_en[gi] = exec_write && (addr == 7'(gi));
            always_ff @(posedge clk) begin
                if (rst) begin
                    reg_q <= 8'h00;
                end else if (wr_en[gi]) begin
                    reg_q <= data_q;
                end
            end
            assign cfg_regs[8*gi +: 8] = reg_q;
        end
    endgenerate

    // Read mux. An out-of-range address reads 0, but that value is never sent
    // because such a frame is answered with a NAK only.
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 7'(i)) begin
                rd_byte = cfg_regs[8*i +: 8];
            end
        end
    end

`ifdef UART_CMD_TIMEOUT_EN
    localparam int            TMO_W   = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_q;
`endif

    // Frame parser. TX_START is used here as the wait state that holds the
    // parser while uart_tx_sched sends the response. Bytes received in that
    // state are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= 8'h00;
            data_q       <= 8'h00;
            csum_q       <= 8'h00;
            cfg_update_q <= 1'b0;
            cfg_addr_q   <= 7'd0;
            req_q        <= 1'b0;
            two_q        <= 1'b0;
            byte0_q      <= 8'h00;
            byte1_q      <= 8'h00;
`ifdef UART_CMD_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            cfg_update_q <= 1'b0;
            req_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid && rx_data == HDR_BYTE) begin
                        state_q <= GET_CMD;
                    end
                end
                GET_CMD: begin
                    if (rx_valid) begin
                        cmd_q   <= rx_data;
                        state_q <= GET_DATA;
                    end
                end
                GET_DATA: begin
                    if (rx_valid) begin
                        data_q  <= rx_data;
                        state_q <= GET_CSUM;
                    end
                end
                GET_CSUM: begin
                    if (rx_valid) begin
                        csum_q  <= rx_data;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    req_q   <= 1'b1;
                    two_q   <= is_read && frame_good;
                    byte0_q <= frame_good ? ACK_BYTE : NAK_BYTE;
                    byte1_q <= rd_byte;
                    if (exec_write) begin
                        cfg_update_q <= 1'b1;
                        cfg_addr_q   <= addr;
                    end
                    state_q <= TX_START;
                end
                TX_START: begin
                    if (tx_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef UART_CMD_TIMEOUT_EN
            // Inter-byte gap counter. Reaching the limit abandons the frame
            // without a response. The state assignment here overrides the case
            // above, which cannot advance anyway because no byte arrived.
            if (state_q == GET_CMD || state_q == GET_DATA || state_q == GET_CSUM) begin
                if (rx_valid) begin
                    tmo_q <= '0;
                end else if (tmo_q == TMO_MAX) begin
                    tmo_q   <= '0;
                    state_q <= IDLE;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
`endif
        end
    end

    uart_tx_sched u_tx_sched (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_q),
        .two_i      (two_q),
        .byte0_i    (byte0_q),
        .byte1_i    (byte1_q),
        .tx_busy_i  (tx_busy),
        .tx_data_o  (tx_data),
        .tx_start_o (tx_start),
        .done_o     (tx_done)
    );

    assign cfg_update = cfg_update_q;
    assign cfg_addr   = cfg_addr_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed testbench for uart_cmd_ctrl. A small transmitter model answers
// tx_start by holding tx_busy high for 5 cycles. It records every transmitted
// byte and every cfg_update pulse, and counts handshake violations.
module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [31:0] cfg_regs;
    logic        cfg_update;
    logic [6:0]  cfg_addr;

    int checks = 0;
    int errors = 0;

    uart_cmd_ctrl #(
        .NUM_REGS    (4),
        .HDR_BYTE    (8'hA5),
        .TIMEOUT_CYC (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .cfg_regs   (cfg_regs),
        .cfg_update (cfg_update),
        .cfg_addr   (cfg_addr)
    );

    always #5 clk = ~clk;

    // Transmitter model and event recorder
    int         cyc = 0;
    logic [7:0] tx_log[$];
    int         start_cyc[$];
    int         busy_cnt = 0;
    logic [7:0] held_data = 8'h00;
    int         viol_busy = 0;
    int         viol_stable = 0;
    int         upd_cnt = 0;
    int         upd_last_cyc = -1;
    logic [6:0] upd_last_addr = 7'd0;
    int         last_rx_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            tx_busy  <= 1'b0;
            busy_cnt <= 0;
        end else begin
            if (tx_start) begin
                if (tx_busy) viol_busy <= viol_busy + 1;
                tx_log.push_back(tx_data);
                start_cyc.push_back(cyc);
                held_data <= tx_data;
                tx_busy   <= 1'b1;
                busy_cnt  <= 5;
            end else if (busy_cnt > 0) begin
                if (tx_data !== held_data) viol_stable <= viol_stable + 1;
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) tx_busy <= 1'b0;
            end
            if (cfg_update) begin
                upd_cnt       <= upd_cnt + 1;
                upd_last_cyc  <= cyc;
                upd_last_addr <= cfg_addr;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data     = b;
        rx_valid    = 1'b1;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        $display("frame %02h %02h %02h %02h", b0, b1, b2, b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic settle();
        repeat (40) @(negedge clk);
    endtask

    task automatic test_reset();
        int n0;
        n0 = tx_log.size();
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cfg_regs !== 32'h0) begin errors++; $display("FAIL reset_regs: got %h expected %h", cfg_regs, 32'h0); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (cfg_update !== 1'b0) begin errors++; $display("FAIL reset_cfg_update: got %b expected 0", cfg_update); end
        checks++; if (cfg_addr !== 7'd0) begin errors++; $display("FAIL reset_cfg_addr: got %h expected 0", cfg_addr); end
        rst      = 1'b0;
        rx_valid = 1'b0;
        // A header seen only during reset must not start a frame.
        $display("bytes 01 10 11 after header-in-reset");
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h11);
        settle();
        checks++; if (tx_log.size() - n0 !== 0) begin errors++; $display("FAIL reset_rx_ignored: got %0d tx bytes expected 0", tx_log.size() - n0); end
        checks++; if (cfg_regs !== 32'h0) begin errors++; $display("FAIL reset_rx_regs: got %h expected %h", cfg_regs, 32'h0); end
    endtask

    task automatic test_write();
        int n0, u0;
        n0 = tx_log.size(); u0 = upd_cnt;
        send_frame(8'hA5, 8'h02, 8'h3C, 8'h3E);
        settle();
        checks++; if (cfg_regs !== 32'h003C0000) begin errors++; $display("FAIL write_regs: got %h expected %h", cfg_regs, 32'h003C0000); end
        checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL write_upd_count: got %0d expected 1", upd_cnt - u0); end
        checks++; if (upd_last_addr !== 7'd2) begin errors++; $display("FAIL write_cfg_addr: got %0d expected 2", upd_last_addr); end
        checks++; if (upd_last_cyc !== last_rx_cyc + 2) begin errors++; $display("FAIL write_upd_timing: got cycle %0d expected %0d", upd_last_cyc, last_rx_cyc + 2); end
        checks++; if (tx_log.size() - n0 !== 1) begin errors++; $display("FAIL write_tx_count: got %0d expected 1", tx_log.size() - n0); end
        checks++; if (tx_log[n0] !== 8'h06) begin errors++; $display("FAIL write_ack: got %h expected 06", tx_log[n0]); end
        checks++; if (start_cyc[n0] - last_rx_cyc < 2) begin errors++; $display("FAIL write_latency: got %0d cycles expected at least 2", start_cyc[n0] - last_rx_cyc); end
    endtask

    task automatic test_read();
        int n0, u0;
        n0 = tx_log.size(); u0 = upd_cnt;
        send_frame(8'hA5, 8'h82, 8'h00, 8'h82);
        settle();
        checks++; if (tx_log.size() - n0 !== 2) begin errors++; $display("FAIL read_tx_count: got %0d expected 2", tx_log.size() - n0); end
        checks++; if (tx_log[n0] !== 8'h06) begin errors++; $display("FAIL read_ack: got %h expected 06", tx_log[n0]); end
        checks++; if (tx_log[n0+1] !== 8'h3C) begin errors++; $display("FAIL read_data: got %h expected 3C", tx_log[n0+1]); end
        checks++; if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL read_no_update: got %0d expected 0", upd_cnt - u0); end
        checks++; if (viol_busy !== 0) begin errors++; $display("FAIL read_start_while_busy: got %0d expected 0", viol_busy); end
        checks++; if (viol_stable !== 0) begin errors++; $display("FAIL read_tx_data_stable: got %0d expected 0", viol_stable); end
        checks++; if (cfg_regs !== 32'h003C0000) begin errors++; $display("FAIL read_regs: got %h expected %h", cfg_regs, 32'h003C0000); end
    endtask

    task automatic test_bad_frames();
        int n0, u0;
        n0 = tx_log.size(); u0 = upd_cnt;
        send_frame(8'hA5, 8'h01, 8'h55, 8'h00);
        settle();
        checks++; if (tx_log[n0] !== 8'h15) begin errors++; $display("FAIL bad_csum_nak: got %h expected 15", tx_log[n0]); end
        checks++; if (cfg_regs !== 32'h003C0000) begin errors++; $display("FAIL bad_csum_regs: got %h expected %h", cfg_regs, 32'h003C0000); end
        send_frame(8'hA5, 8'h04, 8'h11, 8'h15);
        settle();
        checks++; if (tx_log[n0+1] !== 8'h15) begin errors++; $display("FAIL bad_addr_nak: got %h expected 15", tx_log[n0+1]); end
        checks++; if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL bad_no_update: got %0d expected 0", upd_cnt - u0); end
        checks++; if (cfg_regs !== 32'h003C0000) begin errors++; $display("FAIL bad_addr_regs: got %h expected %h", cfg_regs, 32'h003C0000); end
        send_frame(8'hA5, 8'h03, 8'hFF, 8'hFC);
        settle();
        checks++; if (tx_log[n0+2] !== 8'h06) begin errors++; $display("FAIL top_addr_ack: got %h expected 06", tx_log[n0+2]); end
        checks++; if (tx_log.size() - n0 !== 3) begin errors++; $display("FAIL bad_tx_count: got %0d expected 3", tx_log.size() - n0); end
        checks++; if (cfg_regs !== 32'hFF3C0000) begin errors++; $display("FAIL top_addr_regs: got %h expected %h", cfg_regs, 32'hFF3C0000); end
        checks++; if (upd_last_addr !== 7'd3) begin errors++; $display("FAIL top_addr_cfg_addr: got %0d expected 3", upd_last_addr); end
    endtask

    task automatic test_noise();
        int n0;
        n0 = tx_log.size();
        $display("noise 00 FF");
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'hA5, 8'h01, 8'h10, 8'h11);
        settle();
        checks++; if (tx_log.size() - n0 !== 1) begin errors++; $display("FAIL noise_tx_count: got %0d expected 1", tx_log.size() - n0); end
        checks++; if (tx_log[n0] !== 8'h06) begin errors++; $display("FAIL noise_ack: got %h expected 06", tx_log[n0]); end
        checks++; if (cfg_regs !== 32'hFF3C1000) begin errors++; $display("FAIL noise_regs: got %h expected %h", cfg_regs, 32'hFF3C1000); end
    endtask

    task automatic test_back_to_back();
        int n0, waited;
        n0 = tx_log.size();
        send_frame(8'hA5, 8'h02, 8'h77, 8'h75);
        waited = 0;
        while (tx_busy !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL overlap_busy_seen: got %b expected 1 within 50 cycles", tx_busy); end
        $display("extra byte A5 while busy");
        send_byte(8'hA5);
        settle();
        checks++; if (tx_log.size() - n0 !== 1) begin errors++; $display("FAIL overlap_tx_count: got %0d expected 1", tx_log.size() - n0); end
        checks++; if (tx_log[n0] !== 8'h06) begin errors++; $display("FAIL overlap_ack: got %h expected 06", tx_log[n0]); end
        send_frame(8'hA5, 8'h01, 8'h20, 8'h21);
        settle();
        checks++; if (tx_log[n0+1] !== 8'h06) begin errors++; $display("FAIL overlap_next_ack: got %h expected 06", tx_log[n0+1]); end
        checks++; if (cfg_regs !== 32'hFF772000) begin errors++; $display("FAIL overlap_regs: got %h expected %h", cfg_regs, 32'hFF772000); end
    endtask

    task automatic test_reset_mid_frame();
        int n0, u0;
        n0 = tx_log.size(); u0 = upd_cnt;
        $display("partial frame A5 01 then reset");
        send_byte(8'hA5);
        send_byte(8'h01);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++; if (cfg_regs !== 32'h0) begin errors++; $display("FAIL midrst_cleared: got %h expected %h", cfg_regs, 32'h0); end
        $display("bytes 10 11 after reset");
        send_byte(8'h10);
        send_byte(8'h11);
        settle();
        checks++; if (tx_log.size() - n0 !== 0) begin errors++; $display("FAIL midrst_no_tx: got %0d expected 0", tx_log.size() - n0); end
        checks++; if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL midrst_no_update: got %0d expected 0", upd_cnt - u0); end
        send_frame(8'hA5, 8'h01, 8'h10, 8'h11);
        settle();
        checks++; if (tx_log[n0] !== 8'h06) begin errors++; $display("FAIL midrst_ack: got %h expected 06", tx_log[n0]); end
        checks++; if (cfg_regs !== 32'h00001000) begin errors++; $display("FAIL midrst_regs: got %h expected %h", cfg_regs, 32'h00001000); end
    endtask

    task automatic test_timeout();
        int n0;
        n0 = tx_log.size();
        $display("slow frame A5 01 .. gap 25 ..");
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (25) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
        send_byte(8'h10);
        send_byte(8'h11);
        settle();
        checks++; if (tx_log.size() - n0 !== 0) begin errors++; $display("FAIL timeout_no_tx: got %0d expected 0", tx_log.size() - n0); end
        checks++; if (cfg_regs !== 32'h00001000) begin errors++; $display("FAIL timeout_regs: got %h expected %h", cfg_regs, 32'h00001000); end
        send_frame(8'hA5, 8'h01, 8'h33, 8'h32);
        settle();
        checks++; if (tx_log[n0] !== 8'h06) begin errors++; $display("FAIL timeout_next_ack: got %h expected 06", tx_log[n0]); end
        checks++; if (cfg_regs !== 32'h00003300) begin errors++; $display("FAIL timeout_next_regs: got %h expected %h", cfg_regs, 32'h00003300); end
`else
        send_byte(8'h44);
        send_byte(8'h45);
        settle();
        checks++; if (tx_log.size() - n0 !== 1) begin errors++; $display("FAIL slow_tx_count: got %0d expected 1", tx_log.size() - n0); end
        checks++; if (tx_log[n0] !== 8'h06) begin errors++; $display("FAIL slow_ack: got %h expected 06", tx_log[n0]); end
        checks++; if (cfg_regs !== 32'h00004400) begin errors++; $display("FAIL slow_regs: got %h expected %h", cfg_regs, 32'h00004400); end
`endif
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_bad_frames();
        test_noise();
        test_back_to_back();
        test_reset_mid_frame();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer that sits between the UART byte receiver/transmitter pair and the video-splicing datapath.
- Assembles received bytes into 4-byte command frames, validates them, and updates a bank of 8-bit configuration registers (channel select, splice mode, etc.).
- Answers every frame with ACK/NAK, plus a data byte for reads, by driving the UART transmitter through a start/busy handshake.

Parameters:
- NUM_REGS, 4: number of 8-bit config registers; legal addresses are 0..NUM_REGS-1, with NUM_REGS ≤ 127.
- HDR_BYTE, 8'hA5: frame header byte.
- TIMEOUT_CYC, 50_000_000: maximum idle cycles allowed between bytes of one frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- tx_busy  in  1  transmitter busy; goes high the cycle after tx_start and stays high until the byte has been sent
- tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls
- tx_start  out  1  one-cycle transmit request
- cfg_regs  out  8*NUM_REGS  flattened register bank; reg i occupies bits [8i+7:8i]
- cfg_update  out  1  one-cycle pulse when a register is written
- cfg_addr  out  7  address of the last written register

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. While rst=1, all outputs are driven to 0, cfg_regs is cleared, and the FSM enters IDLE. Asserting rst mid-frame or mid-transmit aborts immediately; no further tx_start is issued.
- Frame format: HDR, CMD, DATA, CSUM.
  - CMD[7] = 1 means read, 0 means write. CMD[6:0] is the address.
  - CSUM must equal CMD ^ DATA.
- FSM states: IDLE, GET_CMD, GET_DATA, GET_CSUM, EXEC, TX_START, TX_WAIT_HI, TX_WAIT_LO.
- IDLE: a byte equal to HDR_BYTE moves to GET_CMD. Any other byte is discarded.
- GET_CMD / GET_DATA / GET_CSUM: each captures one byte on rx_valid and advances; GET_CSUM advances to EXEC.
- EXEC (1 cycle): the frame is good if CSUM matches and address < NUM_REGS.
  - Good write: the register updates on this cycle's clock edge; cfg_update=1 and cfg_addr=address in the following cycle. Response is ACK 8'h06.
  - Good read: response is ACK 8'h06 followed by the register value.
  - Bad frame: no register change and no cfg_update. Response is NAK 8'h15 only.
- TX_START: waits until tx_busy=0, then pulses tx_start for one cycle with tx_data loaded.
- TX_WAIT_HI: waits for tx_busy=1.
- TX_WAIT_LO: waits for tx_busy=0. Then either loops back to TX_START for the second byte of a read, or returns to IDLE.
- Latency: the first tx_start occurs no earlier than 2 cycles after the CSUM rx_valid, assuming tx_busy=0.
- Bytes arriving in EXEC or any TX_* state are dropped. The parser restarts only after returning to IDLE.
- A rx_valid in the same cycle as rst is ignored.
- Address boundary: address = NUM_REGS-1 is legal; address = NUM_REGS is NAKed.
- cfg_regs changes only on a good write and holds its value otherwise.

Optional Feature:
- Macro: UART_CMD_TIMEOUT_EN.
- Defined: a cycle counter runs in GET_CMD, GET_DATA and GET_CSUM and resets on every rx_valid. When the counter reaches TIMEOUT_CYC-1, the FSM returns to IDLE silently with no NAK and no register change. The counter width is $clog2(TIMEOUT_CYC).
- Undefined: no counter exists, and the parser waits indefinitely for the remaining bytes.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the FSM state enum;
  - constants ACK_BYTE=8'h06, NAK_BYTE=8'h15, HDR_DEFAULT=8'hA5;
  - the CMD read-bit index (7).
- One sub-module, uart_tx_sched, owns the states TX_START, TX_WAIT_HI and TX_WAIT_LO. It takes a one- or two-byte response request and signals done. The parser and register bank stay in the top module.

Test Plan:
- Write: after reset, send A5 02 3C 3E with the tx model idle → reg2=8'h3C; one cfg_update pulse with cfg_addr=2; tx bytes 06; other registers remain 0.
- Read: after the write above, send A5 82 00 82 → tx sequence 06 then 3C; each tx_start is issued only after tx_busy has fallen; cfg_update stays 0.
- Bad checksum and bad address:
  - A5 01 55 00 → NAK 15, reg1 unchanged.
  - A5 04 11 15 with NUM_REGS=4 → NAK 15.
  - A5 03 FF FC → ACK, reg3=FF.
- Noise and overlap:
  - Bytes 00 FF before A5 01 10 11 → ignored; reg1=10.
  - Inject an extra A5 byte while tx_busy=1 → dropped; exactly one response is sent.
- Reset mid-frame: send A5 01, assert rst for 1 cycle, then send 10 11 → no update and no tx. Then send A5 01 10 11 → reg1=10, ACK.
- Timeout (UART_CMD_TIMEOUT_EN defined, TIMEOUT_CYC=20): send A5 01, wait 25 cycles, send 10 11 → no response. The next full frame is accepted normally.
